// File: rtl/circle_intersections.sv
// Two-circle intersection solver: shared squaring, restoring sqrt and restoring divide, sequenced by one FSM.
// Optional no_int flag port enabled by defining CIRCLE_INTERSECT_NOINT_EN.
module circle_intersections #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3*N:0]     g_input,
  input  logic [3*N:0]     e_input,
  output logic             busy,
  output logic             done,
  output logic [4*N-1:0]   o
`ifdef CIRCLE_INTERSECT_NOINT_EN
  ,
  output logic             no_int
`endif
);
  localparam int DW  = N + 1;
  localparam int DSW = 2*N + 3;
  localparam int R2W = 2*N + 2;
  localparam int KW  = 2*N + 4;
  localparam int QW  = 4*N + 8;
  localparam int SW  = QW / 2;
  localparam int RW  = SW + 2;
  localparam int NW  = 3*N + 6;
  localparam int DVW = DSW + 1;
  localparam int CW  = $clog2(NW + 1);
  localparam logic [CW-1:0] SQ_LAST = CW'(SW - 1);
  localparam logic [CW-1:0] DV_LAST = CW'(NW);

  // Handshake: start is honoured only in IDLE; busy covers the whole computation; done pulses once.
  typedef enum logic [2:0] {IDLE, SQR, ROOT, DIV, OUT} state_t;
  state_t state;

  logic signed [N-1:0]  xb_in, yb_in, xc_in, yc_in;
  logic [N:0]           rb_in, rc_in;
  assign xb_in = g_input[3*N:2*N+1];
  assign yb_in = g_input[2*N:N+1];
  assign rb_in = g_input[N:0];
  assign xc_in = e_input[3*N:2*N+1];
  assign yc_in = e_input[2*N:N+1];
  assign rc_in = e_input[N:0];

  logic signed [N-1:0]  xb, yb;
  logic signed [DW-1:0] dx, dy;
  logic [R2W-1:0]       rb2, rc2;
  logic [DSW-1:0]       d;
  logic signed [KW-1:0] k;
  logic                 phase;
  logic                 degen;
  logic [QW-1:0]        rad;
  logic [RW-1:0]        sq_rem;
  logic [SW-1:0]        s;
  logic [NW-1:0]        dvd;
  logic [DVW:0]         dv_rem;
  logic                 neg;
  logic [CW-1:0]        cnt;
  logic [1:0]           idx;
  logic [N-1:0]         res [4];

  logic signed [DW-1:0]  dx_c, dy_c;
  logic [R2W-1:0]        rb2_c, rc2_c;
  logic signed [DSW-1:0] dxe, dye, d_c;
  logic signed [KW-1:0]  k_c;
  logic [QW-1:0]         q_c;
  assign dx_c  = DW'(xc_in) - DW'(xb_in);
  assign dy_c  = DW'(yc_in) - DW'(yb_in);
  assign rb2_c = R2W'(rb_in) * R2W'(rb_in);
  assign rc2_c = R2W'(rc_in) * R2W'(rc_in);
  assign dxe   = DSW'(dx);
  assign dye   = DSW'(dy);
  assign d_c   = dxe * dxe + dye * dye;
  assign k_c   = KW'(rb2) - KW'(rc2) + KW'(d_c);
  assign q_c   = ((QW'(rb2) * QW'(d)) << 2) - (QW'(k) * QW'(k));

  // Restoring square root: bring down two radicand bits, try (root<<2)|1.
  logic [RW-1:0] sq_acc, sq_trial, sq_diff;
  logic          sq_ge;
  assign sq_acc   = (sq_rem << 2) | RW'(rad[QW-1 -: 2]);
  assign sq_trial = (RW'(s) << 2) | RW'(1);
  assign sq_ge    = sq_acc >= sq_trial;
  assign sq_diff  = sq_acc - sq_trial;

  // Numerator for quotient idx: x1,y1,x2,y2 differ only in operand swap and sign of the S term.
  logic signed [NW-1:0] m_a, m_b, p_a, p_b, num, mag;
  logic [NW-1:0]        dvd_load;
  assign m_a = idx[0] ? NW'(dy) : NW'(dx);
  assign m_b = idx[0] ? NW'(dx) : NW'(dy);
  assign p_a = m_a * NW'(k);
  assign p_b = m_b * NW'(s);
  assign num = (idx[0] ^ idx[1]) ? (p_a - p_b) : (p_a + p_b);
  assign mag = num[NW-1] ? -num : num;
  // floor((|num| + D) / 2D) is |num|/2D rounded half away from zero.
  assign dvd_load = mag + NW'(d);

  logic [DVW:0]         dv_acc, dvs, dv_diff;
  logic                 dv_ge;
  logic [NW-1:0]        q_fin;
  logic signed [N-1:0]  base, coord;
  assign dv_acc  = (dv_rem << 1) | (DVW+1)'(dvd[NW-1]);
  assign dvs     = (DVW+1)'({d, 1'b0});
  assign dv_ge   = dv_acc >= dvs;
  assign dv_diff = dv_acc - dvs;
  assign q_fin   = (dvd << 1) | NW'(dv_ge);
  assign base    = idx[0] ? yb : xb;
  assign coord   = base + (neg ? -q_fin[N-1:0] : q_fin[N-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      o      <= '0;
      xb     <= '0;
      yb     <= '0;
      dx     <= '0;
      dy     <= '0;
      rb2    <= '0;
      rc2    <= '0;
      d      <= '0;
      k      <= '0;
      phase  <= 1'b0;
      degen  <= 1'b0;
      rad    <= '0;
      sq_rem <= '0;
      s      <= '0;
      dvd    <= '0;
      dv_rem <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      for (int i = 0; i < 4; i++) res[i] <= '0;
`ifdef CIRCLE_INTERSECT_NOINT_EN
      no_int <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xb    <= xb_in;
            yb    <= yb_in;
            dx    <= dx_c;
            dy    <= dy_c;
            rb2   <= rb2_c;
            rc2   <= rc2_c;
            phase <= 1'b0;
            busy  <= 1'b1;
            state <= SQR;
          end
        end
        SQR: begin
          if (!phase) begin
            d     <= DSW'(d_c);
            k     <= k_c;
            phase <= 1'b1;
          end else begin
            rad    <= q_c;
            sq_rem <= '0;
            s      <= '0;
            cnt    <= '0;
            idx    <= '0;
            degen  <= (d == '0) || q_c[QW-1];
            state  <= ((d == '0) || q_c[QW-1]) ? OUT : ROOT;
          end
        end
        ROOT: begin
          rad    <= rad << 2;
          sq_rem <= sq_ge ? sq_diff : sq_acc;
          s      <= (s << 1) | SW'(sq_ge);
          if (cnt == SQ_LAST) begin
            cnt   <= '0;
            state <= DIV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (cnt == '0) begin
            dvd    <= dvd_load;
            neg    <= num[NW-1];
            dv_rem <= '0;
            cnt    <= cnt + 1'b1;
          end else begin
            dvd    <= q_fin;
            dv_rem <= dv_ge ? dv_diff : dv_acc;
            if (cnt == DV_LAST) begin
              res[idx] <= coord;
              cnt      <= '0;
              idx      <= idx + 2'd1;
              if (idx == 2'd3) state <= OUT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUT: begin
          o     <= degen ? '0 : {res[0], res[1], res[2], res[3]};
          done  <= 1'b1;
          busy  <= 1'b0;
`ifdef CIRCLE_INTERSECT_NOINT_EN
          no_int <= degen;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_circle_intersections.sv
// Scoreboard bench for circle_intersections: directed vectors with hand-computed intersections.
module tb_circle_intersections;
  localparam int N = 8;
  localparam int LAT_MAX = 24*N + 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [3*N:0]   g_input = '0;
  logic [3*N:0]   e_input = '0;
  logic           busy, done;
  logic [4*N-1:0] o;
`ifdef CIRCLE_INTERSECT_NOINT_EN
  logic           no_int;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ref_lat = -1;
  int snap;
  logic [4*N:0] exp_q[$];
  logic [4*N:0] exp_e;

  circle_intersections #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .g_input(g_input), .e_input(e_input),
    .busy(busy), .done(done), .o(o)
`ifdef CIRCLE_INTERSECT_NOINT_EN
    , .no_int(no_int)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [3*N:0] pk(input int x, input int y, input int r);
    logic [N-1:0] xv, yv;
    logic [N:0]   rv;
    xv = x[N-1:0];
    yv = y[N-1:0];
    rv = r[N:0];
    return {xv, yv, rv};
  endfunction

  // monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with o=%h, required no done", o);
      end else begin
        exp_e = exp_q.pop_front();
        check("o", 64'(o), 64'(exp_e[4*N-1:0]));
`ifdef CIRCLE_INTERSECT_NOINT_EN
        check("no_int", 64'(no_int), 64'(exp_e[4*N]));
`endif
      end
    end
  end

  task automatic run_vec(input string name, input int bx, input int by, input int br,
                         input int cx, input int cy, input int cr,
                         input logic [4*N-1:0] eo, input logic eni, input bit fixed);
    int lat;
    @(negedge clk);
    g_input = pk(bx, by, br);
    e_input = pk(cx, cy, cr);
    exp_q.push_back({eni, eo});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 4*LAT_MAX) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      check({name, "_timeout"}, 64'(done), 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      checks++;
      if (lat > LAT_MAX) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, limit %0d", name, lat, LAT_MAX);
      end
      if (fixed) begin
        if (ref_lat < 0) ref_lat = lat;
        else check({name, "_lat_fixed"}, 64'(lat), 64'(ref_lat));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2;
    check("reset_o", 64'(o), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_vec("spec",       -16, -24, 89, 109, -9, 75, 32'h3EBD3124, 1'b0, 1'b1);
    run_vec("concentric",   5,   5, 10,   5,  5, 20, 32'h00000000, 1'b1, 1'b0);
    run_vec("disjoint",     0,   0, 10, 100,  0, 10, 32'h00000000, 1'b1, 1'b0);
    run_vec("tangent",      0,   0, 10,  20,  0, 10, 32'h0A000A00, 1'b0, 1'b1);
    run_vec("horiz",        0,   0,  5,   6,  0,  5, 32'h03FC0304, 1'b0, 1'b1);
    run_vec("vert",         0,   0, 10,   0, 12, 10, 32'h0806F806, 1'b0, 1'b1);
    run_vec("negative",   -10, -10,  5,  -4,-10,  5, 32'hF9F2F9FA, 1'b0, 1'b1);
    run_vec("tie",          0,   0,  1,   1,  0,  1, 32'h01FF0101, 1'b0, 1'b1);

    // start pulsed while busy must be ignored
    snap = done_cnt;
    @(negedge clk);
    g_input = pk(0, 0, 5);
    e_input = pk(6, 0, 5);
    exp_q.push_back({1'b0, 32'h03FC0304});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    g_input = pk(0, 0, 10);
    e_input = pk(20, 0, 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT_MAX + 20) @(negedge clk);
    @(posedge clk);
    check("busy_start_dones", 64'(done_cnt - snap), 64'd1);

    // reset mid-operation aborts at once
    @(negedge clk);
    g_input = pk(-16, -24, 89);
    e_input = pk(109, -9, 75);
    exp_q.push_back({1'b0, 32'h3EBD3124});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_o", 64'(o), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    snap = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT_MAX + 20) @(negedge clk);
    @(posedge clk);
    check("abort_no_done", 64'(done_cnt - snap), 64'd0);

    run_vec("recover",    -16, -24, 89, 109, -9, 75, 32'h3EBD3124, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
